// File: rtl/risc_pkg.sv
// Shared constants for the RISC pipeline: datapath widths, ALU operation codes and branch types.
package risc_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_SLL = 3'd3;
    localparam logic [2:0] ALU_SLR = 3'd4;

    localparam logic [1:0] BR_NONE = 2'd0;
    localparam logic [1:0] BR_EQ   = 2'd1;
    localparam logic [1:0] BR_NE   = 2'd2;
    localparam logic [1:0] BR_LT   = 2'd3;

endpackage

// File: rtl/alu.sv
// 32-bit pipeline ALU: add/sub/and and logical shifts, with zero and negative flags.
module alu
    import risc_pkg::*;
#(
    parameter int unsigned XLEN = risc_pkg::XLEN
) (
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [2:0]      op_i,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o,
    output logic            neg_o
);

    always_comb begin
        result_o = '0;
        unique case (op_i)
            ALU_ADD: result_o = a_i + b_i;
            ALU_SUB: result_o = a_i - b_i;
            ALU_AND: result_o = a_i & b_i;
            // The whole B value is the shift amount, so anything at or past XLEN clears the result
            ALU_SLL: result_o = (b_i < XLEN) ? (a_i << b_i) : '0;
            ALU_SLR: result_o = (b_i < XLEN) ? (a_i >> b_i) : '0;
            default: result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);
    assign neg_o  = result_o[XLEN-1];

endmodule

// File: rtl/fwd_mux.sv
// Operand forwarding for one source register: EX/MEM result first, then writeback, else RF value.
module fwd_mux #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] src_i,
    input  logic [XLEN-1:0]   rf_val_i,
    input  logic              exm_valid_i,
    input  logic              exm_reg_we_i,
    input  logic              exm_mem_rd_i,
    input  logic [REG_AW-1:0] exm_rd_i,
    input  logic [XLEN-1:0]   exm_result_i,
    input  logic              wb_we_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic [XLEN-1:0]   wb_data_i,
    output logic [XLEN-1:0]   val_o
);

    logic src_nonzero;

    assign src_nonzero = (src_i != '0);

    always_comb begin
        val_o = rf_val_i;
        // A load in EX/MEM only holds an address, so it must never be forwarded
        if (exm_valid_i && exm_reg_we_i && !exm_mem_rd_i && exm_rd_i == src_i && src_nonzero) begin
            val_o = exm_result_i;
        end else if (wb_we_i && wb_rd_i == src_i && src_nonzero) begin
            val_o = wb_data_i;
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: forwards operands, runs the ALU, resolves branches and registers the EX/MEM
// entry behind a valid/ready handshake.
module ex_stage #(
    parameter int unsigned XLEN   = risc_pkg::XLEN,
    parameter int unsigned REG_AW = risc_pkg::REG_AW
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_rs1_val,
    input  logic [XLEN-1:0]   in_rs2_val,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [XLEN-1:0]   in_imm,
    input  logic              in_use_imm,
    input  logic [2:0]        in_alu_op,
    input  logic [1:0]        in_br_type,
    input  logic              in_reg_we,
    input  logic              in_mem_rd,
    input  logic              in_mem_wr,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_result,
    output logic [XLEN-1:0]   out_store_data,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_reg_we,
    output logic              out_mem_rd,
    output logic              out_mem_wr,
    output logic              br_taken,
    output logic [XLEN-1:0]   br_target
);

    import risc_pkg::*;

    logic [XLEN-1:0]   rs1_fwd, rs2_fwd, op_b, alu_result;
    logic              alu_zero, alu_neg, br_cond, accept, hold;

    logic              valid_q, valid_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [XLEN-1:0]   store_q, store_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic              reg_we_q, reg_we_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;
    logic              br_taken_q, br_taken_d;
    logic [XLEN-1:0]   br_target_q, br_target_d;

    assign hold     = valid_q && !out_ready;
    assign in_ready = !hold;
    assign accept   = in_valid && in_ready;

    fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
        .src_i        (in_rs1),
        .rf_val_i     (in_rs1_val),
        .exm_valid_i  (valid_q),
        .exm_reg_we_i (reg_we_q),
        .exm_mem_rd_i (mem_rd_q),
        .exm_rd_i     (rd_q),
        .exm_result_i (result_q),
        .wb_we_i      (wb_we),
        .wb_rd_i      (wb_rd),
        .wb_data_i    (wb_data),
        .val_o        (rs1_fwd)
    );

    fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
        .src_i        (in_rs2),
        .rf_val_i     (in_rs2_val),
        .exm_valid_i  (valid_q),
        .exm_reg_we_i (reg_we_q),
        .exm_mem_rd_i (mem_rd_q),
        .exm_rd_i     (rd_q),
        .exm_result_i (result_q),
        .wb_we_i      (wb_we),
        .wb_rd_i      (wb_rd),
        .wb_data_i    (wb_data),
        .val_o        (rs2_fwd)
    );

    assign op_b = in_use_imm ? in_imm : rs2_fwd;

    alu #(.XLEN(XLEN)) u_alu (
        .a_i      (rs1_fwd),
        .b_i      (op_b),
        .op_i     (in_alu_op),
        .result_o (alu_result),
        .zero_o   (alu_zero),
        .neg_o    (alu_neg)
    );

    always_comb begin
        br_cond = 1'b0;
        unique case (in_br_type)
            BR_EQ:   br_cond = alu_zero;
            BR_NE:   br_cond = !alu_zero;
            BR_LT:   br_cond = alu_neg;
            default: br_cond = 1'b0;
        endcase
    end

    always_comb begin
        valid_d     = valid_q;
        result_d    = result_q;
        store_d     = store_q;
        rd_d        = rd_q;
        reg_we_d    = reg_we_q;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        br_target_d = br_target_q;
        // br_taken is a single pulse; holding a stalled entry never repeats it
        br_taken_d  = 1'b0;
        if (accept) begin
            valid_d     = !flush;
            result_d    = alu_result;
            store_d     = rs2_fwd;
            rd_d        = in_rd;
            reg_we_d    = in_reg_we;
            mem_rd_d    = in_mem_rd;
            mem_wr_d    = in_mem_wr;
            br_target_d = in_pc + in_imm;
            br_taken_d  = br_cond && !flush;
        end else if (!hold) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q     <= 1'b0;
            result_q    <= '0;
            store_q     <= '0;
            rd_q        <= '0;
            reg_we_q    <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            br_taken_q  <= 1'b0;
            br_target_q <= '0;
        end else begin
            valid_q     <= valid_d;
            result_q    <= result_d;
            store_q     <= store_d;
            rd_q        <= rd_d;
            reg_we_q    <= reg_we_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            br_taken_q  <= br_taken_d;
            br_target_q <= br_target_d;
        end
    end

    assign out_valid      = valid_q;
    assign out_result     = result_q;
    assign out_store_data = store_q;
    assign out_rd         = rd_q;
    assign out_reg_we     = reg_we_q;
    assign out_mem_rd     = mem_rd_q;
    assign out_mem_wr     = mem_wr_q;
    assign br_taken       = br_taken_q;
    assign br_target      = br_target_q;

endmodule
